conv_frame_scheduler: RTL and testbench

Frame-level controller that sequences one shared complex multiply-accumulate unit to compute an N_TAPS complex FIR convolution over a frame of N_SAMPLES complex samples. It sits between the sample source and the result sink in the convolution datapath. It buffers one input frame, holds a run-time programmable coefficient bank, and emits the centre-aligned ("same"-length) output stream with valid/ready handshakes. It replaces the fully unrolled, simulation-only convolution loop with a synthesizable, time-multiplexed schedule.

---
 rtl/conv_frame_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_conv_frame_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_scheduler.sv
// conv_frame_scheduler
// Frame-level controller that time-multiplexes one complex multiply-accumulate
// to compute a centre-aligned ("same"-length) N_TAPS complex FIR over a frame
// of N_SAMPLES complex samples.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 begin a frame (honoured only when idle)
//   busy, done            frame in flight / one-cycle completion pulse
//   in_valid, in_ready    sample handshake, in_r/in_i signed DW-bit sample
//   coef_we, coef_addr    coefficient write (ignored while busy or addr >= N_TAPS)
//   coef_r, coef_i        signed CW-bit coefficient
//   out_valid, out_ready  result handshake
//   out_idx               output index 0..N_SAMPLES-1
//   out_r, out_i          signed AW-bit result (wraps modulo 2^AW)
module conv_frame_scheduler #(
  parameter int N_SAMPLES = 100,
  parameter int N_TAPS    = 11,
  parameter int DW        = 16,
  parameter int CW        = 8,
  parameter int AW        = 32,
  localparam int KW       = $clog2(N_SAMPLES),
  localparam int TW       = $clog2(N_TAPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  input  logic                 coef_we,
  input  logic        [TW-1:0] coef_addr,
  input  logic signed [CW-1:0] coef_r,
  input  logic signed [CW-1:0] coef_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic        [KW-1:0] out_idx,
  output logic signed [AW-1:0] out_r,
  output logic signed [AW-1:0] out_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_EMIT,
    S_DONE
  } state_e;

  // Centre alignment: output k is formed from samples k+OFF-j, j = 0..N_TAPS-1.
  localparam int OFF = (N_TAPS - 1) / 2;
  // Width of the signed sample index; wide enough for both under- and overshoot.
  localparam int MW  = KW + TW + 1;

  localparam logic        [KW-1:0] K_LAST  = KW'(N_SAMPLES - 1);
  localparam logic        [TW-1:0] J_LAST  = TW'(N_TAPS - 1);
  localparam logic signed [MW-1:0] M_LIMIT = MW'(N_SAMPLES);

  // Default tap set: real-valued symmetric kernel, imaginary part zero.
  function automatic logic signed [CW-1:0] reset_coef_r(input int j);
    case (j)
      0, 10:   reset_coef_r = CW'(1);
      2, 8:    reset_coef_r = CW'(2);
      4, 6:    reset_coef_r = CW'(3);
      5:       reset_coef_r = CW'(4);
      default: reset_coef_r = '0;
    endcase
  endfunction

  // Storage
  logic signed [DW-1:0] x_r_mem [N_SAMPLES];
  logic signed [DW-1:0] x_i_mem [N_SAMPLES];
  logic signed [CW-1:0] c_r_q   [N_TAPS];
  logic signed [CW-1:0] c_i_q   [N_TAPS];

  // Control and datapath state
  state_e               state_q,  state_d;
  logic        [KW-1:0] ptr_q,    ptr_d;
  logic        [KW-1:0] k_q,      k_d;
  logic        [TW-1:0] j_q,      j_d;
  logic signed [AW-1:0] acc_r_q,  acc_r_d;
  logic signed [AW-1:0] acc_i_q,  acc_i_d;
  logic                 busy_q, done_q, in_ready_q, out_valid_q;

  // Tap addressing
  logic signed [MW-1:0] tap_m;
  logic                 tap_in_range;
  logic        [KW-1:0] tap_idx;
  logic signed [AW-1:0] xr_ext, xi_ext, cr_ext, ci_ext;

  logic in_hs;
  logic coef_wr;

  assign in_hs   = in_valid && in_ready_q;
  assign coef_wr = coef_we && !busy_q && (coef_addr <= J_LAST);

  always_comb begin
    tap_m        = MW'(k_q) + MW'(OFF) - MW'(j_q);
    tap_in_range = !tap_m[MW-1] && (tap_m < M_LIMIT);
    tap_idx      = tap_in_range ? tap_m[KW-1:0] : '0;
    // Full-width signed operands: products and sums wrap modulo 2^AW.
    xr_ext       = AW'(x_r_mem[tap_idx]);
    xi_ext       = AW'(x_i_mem[tap_idx]);
    cr_ext       = AW'(c_r_q[j_q]);
    ci_ext       = AW'(c_i_q[j_q]);
  end

  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    k_d     = k_q;
    j_d     = j_q;
    acc_r_d = acc_r_q;
    acc_i_d = acc_i_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
      end
      S_LOAD: begin
        if (in_hs) begin
          if (ptr_q == K_LAST) begin
            state_d = S_COMPUTE;
            k_d     = '0;
            j_d     = '0;
            acc_r_d = '0;
            acc_i_d = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        // Out-of-range taps still consume their cycle to keep a fixed cadence.
        if (tap_in_range) begin
          acc_r_d = acc_r_q + xr_ext * cr_ext - xi_ext * ci_ext;
          acc_i_d = acc_i_q + xr_ext * ci_ext + xi_ext * cr_ext;
        end
        if (j_q == J_LAST) begin
          j_d     = '0;
          state_d = S_EMIT;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (k_q == K_LAST) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 1'b1;
            acc_r_d = '0;
            acc_i_d = '0;
            state_d = S_COMPUTE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      k_q         <= '0;
      j_q         <= '0;
      acc_r_q     <= '0;
      acc_i_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      k_q         <= k_d;
      j_q         <= j_d;
      acc_r_q     <= acc_r_d;
      acc_i_q     <= acc_i_d;
      // Status flags are registered from the next state so they line up
      // with the state they describe.
      busy_q      <= (state_d == S_LOAD) || (state_d == S_COMPUTE) || (state_d == S_EMIT);
      done_q      <= (state_d == S_DONE);
      in_ready_q  <= (state_d == S_LOAD);
      out_valid_q <= (state_d == S_EMIT);
    end
  end

  // NOTE: the sample buffer has no reset; every entry is written before it is
  // read in a frame, so a reset would only cost a clear network on a RAM.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      x_r_mem[ptr_q] <= in_r;
      x_i_mem[ptr_q] <= in_i;
    end
  end

  // Coefficient bank does revert on reset, to the default tap set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < N_TAPS; t++) begin
        c_r_q[t] <= reset_coef_r(t);
        c_i_q[t] <= '0;
      end
    end else if (coef_wr) begin
      c_r_q[coef_addr] <= coef_r;
      c_i_q[coef_addr] <= coef_i;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_idx   = k_q;
  assign out_r     = acc_r_q;
  assign out_i     = acc_i_q;

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Self-checking bench for conv_frame_scheduler: directed frames, expected
// results pushed to a scoreboard queue and popped by an independent monitor.
module tb_conv_frame_scheduler;

  localparam int NS = 100;
  localparam int NT = 11;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int AW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_r, in_i;
  logic                 coef_we;
  logic        [3:0]    coef_addr;
  logic signed [CW-1:0] coef_r, coef_i;
  logic                 out_valid;
  logic                 out_ready;
  logic        [6:0]    out_idx;
  logic signed [AW-1:0] out_r, out_i;

  conv_frame_scheduler #(
    .N_SAMPLES(NS), .N_TAPS(NT), .DW(DW), .CW(CW), .AW(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_r     (in_r),
    .in_i     (in_i),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_r   (coef_r),
    .coef_i   (coef_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_r    (out_r),
    .out_i    (out_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int r;
    int i;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   bp_cycles = 0;
  int   done_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int                   t_in, in_cnt;
  bit                   first_pending, held, expect_done1, expect_done2;
  logic        [6:0]    h_idx;
  logic signed [AW-1:0] h_r, h_i;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_cnt        = 0;
      first_pending = 0;
      held          = 0;
      expect_done1  = 0;
      expect_done2  = 0;
    end else begin
      if (expect_done2) begin
        check("idle_after_done", {done, busy, in_ready}, 0);
        expect_done2 = 0;
      end
      if (expect_done1) begin
        check("done_after_last", {done, busy}, 2'b10);
        expect_done1 = 0;
        expect_done2 = 1;
      end
      if (done) done_cnt++;
      if (in_valid && in_ready) begin
        t_in = cyc;
        in_cnt++;
        if (in_cnt == NS) begin
          in_cnt        = 0;
          first_pending = 1;
        end
      end
      if (out_valid) begin
        if (first_pending) begin
          check("first_out_latency", cyc - t_in, NT + 1);
          first_pending = 0;
        end
        if (held) begin
          check("bp_stable_idx", out_idx, h_idx);
          check("bp_stable_r", out_r, h_r);
          check("bp_stable_i", out_i, h_i);
        end
        if (out_ready) begin
          held = 0;
          if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_output: idx %0d with empty scoreboard", out_idx);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("out_idx", out_idx, e.idx);
            check("out_r", out_r, e.r);
            check("out_i", out_i, e.i);
          end
          if (out_idx == 7'(NS - 1)) begin
            check("frame_cycles", cyc - t_in, NS * (NT + 1) + bp_cycles);
            expect_done1 = 1;
          end
        end else begin
          held  = 1;
          h_idx = out_idx;
          h_r   = out_r;
          h_i   = out_i;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam int K_IMPULSE = 0;  // 1+0i at sample 0, zeros elsewhere
  localparam int K_IMAG    = 1;  // 0+1i everywhere
  localparam int K_CPLX    = 2;  // -32768+7i everywhere

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expected responses.
  task automatic push_expected(input int kind);
    int imp [6]  = '{4, 3, 0, 2, 0, 1};        // default taps c[5..10]
    int edge_sum [5] = '{10, 13, 13, 15, 15};  // partial tap sums near frame edges
    for (int k = 0; k < NS; k++) begin
      exp_t e;
      int   d;
      e.idx = k;
      case (kind)
        K_IMPULSE: begin
          e.r = (k <= 5) ? imp[k] : 0;
          e.i = 0;
        end
        K_IMAG: begin
          d   = (k < NS - 1 - k) ? k : NS - 1 - k;
          e.r = 0;
          e.i = (d < 5) ? edge_sum[d] : 16;
        end
        default: begin
          e.r = -7;
          e.i = -32768;
        end
      endcase
      sb_q.push_back(e);
    end
  endtask

  task automatic start_frame(input bit wr, input logic [3:0] a,
                             input logic signed [CW-1:0] cr, input logic signed [CW-1:0] ci);
    start     = 1'b1;
    coef_we   = wr;
    coef_addr = a;
    coef_r    = cr;
    coef_i    = ci;
    tick;
    start   = 1'b0;
    coef_we = 1'b0;
    check("in_ready_after_start", in_ready, 1);
  endtask

  task automatic load_frame(input int kind, input bit glitch_start);
    for (int s = 0; s < NS; s++) begin
      in_valid = 1'b1;
      case (kind)
        K_IMPULSE: begin in_r = (s == 0) ? 16'sd1 : 16'sd0; in_i = 16'sd0; end
        K_IMAG:    begin in_r = 16'sd0;      in_i = 16'sd1; end
        default:   begin in_r = -16'sd32768; in_i = 16'sd7; end
      endcase
      start = glitch_start && (s == 50);
      tick;
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_r     = '0;
    in_i     = '0;
  endtask

  // Returns in cycle L+2 after the last output handshake.
  task automatic wait_done;
    int n;
    n = 0;
    while (!done && n < 3000) begin
      tick;
      n++;
    end
    if (!done) fail_now("wait_done");
    tick;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_r      = '0;
    in_i      = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_r    = '0;
    coef_i    = '0;
    out_ready = 1'b1;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_i", out_i, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick;

    // Frame 1: impulse, default taps; start during LOAD and a coefficient
    // write during COMPUTE must both be ignored.
    bp_cycles = 0;
    push_expected(K_IMPULSE);
    start_frame(1'b0, 4'd0, 8'sd0, 8'sd0);
    load_frame(K_IMPULSE, 1'b1);
    coef_we   = 1'b1;
    coef_addr = 4'd5;
    coef_r    = 8'sd100;
    coef_i    = 8'sd0;
    tick;
    coef_we = 1'b0;
    wait_done;

    // Frame 2: 0+1i everywhere, 5 cycles of backpressure at output 3.
    bp_cycles = 5;
    push_expected(K_IMAG);
    start_frame(1'b0, 4'd0, 8'sd0, 8'sd0);
    load_frame(K_IMAG, 1'b0);
    begin
      int n;
      n = 0;
      while (!(out_valid && out_idx == 7'd3) && n < 200) begin
        tick;
        n++;
      end
      if (!(out_valid && out_idx == 7'd3)) fail_now("wait_idx3");
    end
    out_ready = 1'b0;
    repeat (5) tick;
    out_ready = 1'b1;
    wait_done;

    // Frame 3: clear all taps while idle, then set c[5]=0+1i together with start.
    bp_cycles = 0;
    for (int a = 0; a < NT; a++) begin
      coef_we   = 1'b1;
      coef_addr = 4'(a);
      coef_r    = 8'sd0;
      coef_i    = 8'sd0;
      tick;
    end
    coef_we = 1'b0;
    push_expected(K_CPLX);
    start_frame(1'b1, 4'd5, 8'sd0, 8'sd1);
    load_frame(K_CPLX, 1'b0);
    wait_done;

    // Frame 4: reset while computing output 40.
    push_expected(K_CPLX);
    start_frame(1'b0, 4'd0, 8'sd0, 8'sd0);
    load_frame(K_CPLX, 1'b0);
    begin
      int n;
      n = 0;
      while (!(out_idx == 7'd40 && !out_valid && busy) && n < 1000) begin
        tick;
        n++;
      end
      if (!(out_idx == 7'd40 && !out_valid && busy)) fail_now("wait_idx40");
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_idx", out_idx, 0);
    check("midrst_out_r", out_r, 0);
    check("midrst_out_i", out_i, 0);
    sb_q.delete();
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    check("idle_after_rst_busy", busy, 0);
    check("idle_after_rst_in_ready", in_ready, 0);

    // Frame 5: impulse again; the taps must be back at the default set.
    push_expected(K_IMPULSE);
    start_frame(1'b0, 4'd0, 8'sd0, 8'sd0);
    load_frame(K_IMPULSE, 1'b0);
    wait_done;
    tick;

    check("done_pulses", done_cnt, 4);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
